// File: rtl/v_dpu_valid_ctrl.sv
// v_dpu_valid_ctrl
// Sequencer feeding the DPU lane-validity generator. It accepts one vector
// operation at a time, issues a single load, streams one shift beat per
// VLANE_NUM-element group under downstream backpressure, and optionally
// follows with the VLANE_NUM-1 partial-result shifts of a reduction.
// vl_o is captured on start acceptance and held until the next acceptance
// because the generator re-samples it every cycle.
// Optional feature: define V_DPU_VALID_CTRL_ABORT_EN to add abort_i, which
// drops an in-flight operation (LOAD/STREAM/PARTIAL) back to IDLE without
// done_o, suppressing any load/shift in the abort cycle.

module v_dpu_valid_ctrl #(
  parameter int MAX_VL_PER_LANE = 256,
  parameter int VLANE_NUM       = 8,
  localparam int VL_W           = $clog2(VLANE_NUM * MAX_VL_PER_LANE)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            start_ready_o,
  input  logic [VL_W-1:0] vl_i,
  input  logic            reduction_i,
  input  logic            beat_ready_i,
`ifdef V_DPU_VALID_CTRL_ABORT_EN
  input  logic            abort_i,
`endif
  output logic            load_o,
  output logic [VL_W-1:0] vl_o,
  output logic            shift_en_o,
  output logic            shift_partial_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int LANE_SH = $clog2(VLANE_NUM);
  // One extra bit so a full-length vector (MAX_VL_PER_LANE beats) fits
  localparam int BEAT_W  = $clog2(MAX_VL_PER_LANE) + 1;
  localparam int PART_W  = $clog2(VLANE_NUM);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] STREAM  = 3'd2;
  localparam logic [2:0] PARTIAL = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic              red_q, red_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [BEAT_W-1:0] beatCnt_q, beatCnt_d;
  logic [PART_W-1:0] partCnt_q, partCnt_d;
  logic [BEAT_W-1:0] beatsCalc;
  logic              lastBeat;
  logic              lastPartial;
  logic              abortHit;

  // Number of lane groups: vl / VLANE_NUM rounded up
  assign beatsCalc = BEAT_W'(vl_q >> LANE_SH) + BEAT_W'(|vl_q[LANE_SH-1:0]);

  assign lastBeat    = (beatCnt_q == (beats_q - BEAT_W'(1)));
  assign lastPartial = (partCnt_q == PART_W'(VLANE_NUM - 2));

`ifdef V_DPU_VALID_CTRL_ABORT_EN
  logic inFlight;
  assign inFlight = (state_q == LOAD) || (state_q == STREAM) || (state_q == PARTIAL);
  assign abortHit = abort_i && inFlight;
`else
  assign abortHit = 1'b0;
`endif

  // Status and generator strobes decode straight from state; strobes are
  // mutually exclusive by construction and squashed in an abort cycle
  assign start_ready_o   = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);
  assign load_o          = (state_q == LOAD) && !abortHit;
  assign shift_en_o      = (state_q == STREAM) && beat_ready_i && !abortHit;
  assign shift_partial_o = (state_q == PARTIAL) && beat_ready_i && !abortHit;
  assign vl_o            = vl_q;

  // Next-state and counter logic for the operation sequence
  always_comb begin
    state_d   = state_q;
    vl_d      = vl_q;
    red_d     = red_q;
    beats_d   = beats_q;
    beatCnt_d = beatCnt_q;
    partCnt_d = partCnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          vl_d    = vl_i;
          red_d   = reduction_i;
          state_d = (vl_i == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        beats_d   = beatsCalc;
        beatCnt_d = '0;
        state_d   = STREAM;
      end
      STREAM: begin
        if (beat_ready_i) begin
          beatCnt_d = beatCnt_q + BEAT_W'(1);
          if (lastBeat) begin
            partCnt_d = '0;
            state_d   = red_q ? PARTIAL : DONE;
          end
        end
      end
      PARTIAL: begin
        if (beat_ready_i) begin
          partCnt_d = partCnt_q + PART_W'(1);
          if (lastPartial) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abortHit) begin
      state_d = IDLE;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      vl_q      <= '0;
      red_q     <= 1'b0;
      beats_q   <= '0;
      beatCnt_q <= '0;
      partCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      vl_q      <= vl_d;
      red_q     <= red_d;
      beats_q   <= beats_d;
      beatCnt_q <= beatCnt_d;
      partCnt_q <= partCnt_d;
    end
  end

endmodule
